// File: rtl/mix_engine_arbiter.sv
// Round-robin arbiter and round sequencer that lends one shared mixing engine
// to NREQ requesters, one multi-round job at a time, with a per-round watchdog.
module mix_engine_arbiter #(
  parameter int NREQ = 4,
  parameter int RW   = 16,
  parameter int TMO  = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NREQ-1:0]                     req,
  input  logic [NREQ*RW-1:0]                  rounds_i,
  output logic [NREQ-1:0]                     gnt,
  output logic [NREQ-1:0]                     done,
  output logic [NREQ-1:0]                     err,
  output logic                                eng_start,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] eng_sel,
  input  logic                                eng_done,
  output logic                                busy,
  output logic [RW-1:0]                       rounds_left,
  output logic [31:0]                         job_cnt
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TMO);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   owner;
  logic [RW-1:0]   left;
  logic [TW-1:0]   timer;
  logic [31:0]     jobs;

  logic            arb_hit;
  logic [SW-1:0]   arb_idx;
  logic [SW-1:0]   ptr_nx;
  logic            tmo_hit;
  logic [NREQ-1:0] own_oh;

  // ptr + i never reaches 2*NREQ, so one conditional subtract replaces a modulo.
  function automatic logic [SW-1:0] wrap_idx(input int v);
    return (v >= NREQ) ? SW'(v - NREQ) : SW'(v);
  endfunction

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_hit && req[wrap_idx(int'(ptr) + i)]) begin
        arb_hit = 1'b1;
        arb_idx = wrap_idx(int'(ptr) + i);
      end
    end
  end

  assign ptr_nx  = (owner == SW'(NREQ - 1)) ? '0 : owner + SW'(1);
  assign tmo_hit = (timer == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_hit) state_nx = GRANT;
      GRANT:   state_nx = (left != '0) ? START : FIN;
      START:   state_nx = WAIT;
      WAIT: begin
        // A round completing on the watchdog's last cycle still counts as done.
        if (eng_done)     state_nx = (left == RW'(1)) ? FIN : START;
        else if (tmo_hit) state_nx = ERR;
      end
      FIN:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      owner <= '0;
      left  <= '0;
      timer <= '0;
      jobs  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            owner <= arb_idx;
            left  <= rounds_i[int'(arb_idx)*RW +: RW];
          end
        end
        START: timer <= '0;
        WAIT: begin
          if (eng_done)      left  <= left - RW'(1);
          else if (!tmo_hit) timer <= timer + TW'(1);
        end
        FIN: begin
          jobs <= jobs + 32'd1;
          ptr  <= ptr_nx;
        end
        ERR: begin
          ptr  <= ptr_nx;
          left <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    own_oh        = '0;
    own_oh[owner] = 1'b1;
  end

  always_comb begin
    gnt       = '0;
    done      = '0;
    err       = '0;
    eng_start = 1'b0;
    case (state)
      GRANT:   gnt       = own_oh;
      START:   eng_start = 1'b1;
      FIN:     done      = own_oh;
      ERR:     err       = own_oh;
      default: ;
    endcase
  end

  assign eng_sel     = owner;
  assign rounds_left = left;
  assign busy        = (state != IDLE);
  assign job_cnt     = jobs;

endmodule

// File: tb/tb_mix_engine_arbiter.sv
// Directed bench for mix_engine_arbiter: arbitration order, round sequencing,
// zero-round jobs, watchdog abort, ignored eng_done and mid-job reset.
module tb_mix_engine_arbiter;
  localparam int NREQ = 4;
  localparam int RW   = 16;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] rounds_i = '0;
  logic [3:0]  gnt, done, err;
  logic        eng_start;
  logic [1:0]  eng_sel;
  logic        eng_done;
  logic        busy;
  logic [15:0] rounds_left;
  logic [31:0] job_cnt;

  logic eng_done_auto = 1'b0;
  logic eng_done_man  = 1'b0;
  assign eng_done = eng_done_auto | eng_done_man;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int eng_delay = 0;
  int eng_cnt   = 0;
  bit hold_req  = 0;

  int         n_start, n_done, n_err;
  int         gnt_cyc, done_cyc, err_cyc, first_start_cyc;
  logic [3:0] gnt_or, done_or, err_or, gnt_first;
  int         grant_seq, left_seq;

  mix_engine_arbiter #(.NREQ(NREQ), .RW(RW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .rounds_i(rounds_i),
    .gnt(gnt), .done(done), .err(err), .eng_start(eng_start),
    .eng_sel(eng_sel), .eng_done(eng_done), .busy(busy),
    .rounds_left(rounds_left), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: answers eng_done eng_delay cycles after each eng_start.
  initial begin
    forever begin
      @(negedge clk);
      eng_done_auto = 1'b0;
      if (rst) eng_cnt = 0;
      else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) eng_done_auto = 1'b1;
        end
        if (eng_start && eng_delay > 0) eng_cnt = eng_delay;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req = '0; rounds_i = '0;
    eng_done_man = 1'b0; eng_delay = 0; hold_req = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_rec();
    n_start = 0; n_done = 0; n_err = 0;
    gnt_cyc = -1; done_cyc = -1; err_cyc = -1; first_start_cyc = -1;
    gnt_or = '0; done_or = '0; err_or = '0; gnt_first = '0;
    grant_seq = 0; left_seq = 0;
  endtask

  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) grant_seq = grant_seq * 10 + i + 1;
        if (gnt_cyc < 0) begin gnt_cyc = cyc; gnt_first = gnt; end
        gnt_or |= gnt;
        if (!hold_req) req = req & ~gnt;
      end
      if (eng_start) begin
        n_start++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        left_seq = left_seq * 10 + int'(rounds_left);
      end
      if (done != '0) begin n_done++; done_or |= done; done_cyc = cyc; end
      if (err != '0)  begin n_err++;  err_or  |= err;  err_cyc  = cyc; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (done !== 4'b0 || err !== 4'b0) begin bad++; $display("FAIL reset_done_err: got %b/%b want 0000/0000", done, err); end
    total++; if (eng_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_start_busy: got %b/%b want 0/0", eng_start, busy); end
    total++; if (eng_sel !== 2'd0 || rounds_left !== 16'd0) begin bad++; $display("FAIL reset_sel_left: got %0d/%0d want 0/0", eng_sel, rounds_left); end
    total++; if (job_cnt !== 32'd0) begin bad++; $display("FAIL reset_job_cnt: got %0d want 0", job_cnt); end
  endtask

  task automatic test_basic();
    int c;
    do_reset();
    clear_rec();
    eng_delay = 2;
    rounds_i = 64'h0000_0000_0000_0003;
    req = 4'b0001;
    c = cyc;
    observe(15);
    total++; if (gnt_cyc != c + 1 || gnt_or !== 4'b0001) begin bad++; $display("FAIL basic_gnt: got cyc %0d %b want cyc %0d 0001", gnt_cyc, gnt_or, c + 1); end
    total++; if (n_start != 3) begin bad++; $display("FAIL basic_starts: got %0d want 3", n_start); end
    total++; if (left_seq != 321) begin bad++; $display("FAIL basic_left_seq: got %0d want 321", left_seq); end
    total++; if (n_done != 1 || done_or !== 4'b0001 || done_cyc != c + 11) begin bad++; $display("FAIL basic_done: got n=%0d %b cyc %0d want n=1 0001 cyc %0d", n_done, done_or, done_cyc, c + 11); end
    total++; if (job_cnt !== 32'd1) begin bad++; $display("FAIL basic_job_cnt: got %0d want 1", job_cnt); end
    total++; if (busy !== 1'b0 || rounds_left !== 16'd0) begin bad++; $display("FAIL basic_idle: got busy=%b left=%0d want 0/0", busy, rounds_left); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_rec();
    eng_delay = 1;
    hold_req = 1;
    rounds_i = 64'h0000_0001_0000_0001;
    req = 4'b0101;
    observe(24);
    total++; if (job_cnt !== 32'd4) begin bad++; $display("FAIL rr_job_cnt_mid: got %0d want 4", job_cnt); end
    req = '0;
    hold_req = 0;
    observe(3);
    total++; if (grant_seq != 13131) begin bad++; $display("FAIL rr_order: got %0d want 13131 (index+1 per grant)", grant_seq); end
    total++; if (n_done != 5 || job_cnt !== 32'd5) begin bad++; $display("FAIL rr_jobs: got done=%0d cnt=%0d want 5/5", n_done, job_cnt); end
  endtask

  task automatic test_zero_rounds();
    int c;
    do_reset();
    clear_rec();
    rounds_i = '0;
    req = 4'b0010;
    c = cyc;
    observe(4);
    total++; if (gnt_cyc != c + 1 || gnt_or !== 4'b0010) begin bad++; $display("FAIL zero_gnt: got cyc %0d %b want cyc %0d 0010", gnt_cyc, gnt_or, c + 1); end
    total++; if (done_cyc != c + 2 || done_or !== 4'b0010) begin bad++; $display("FAIL zero_done: got cyc %0d %b want cyc %0d 0010", done_cyc, done_or, c + 2); end
    total++; if (n_start != 0) begin bad++; $display("FAIL zero_no_start: got %0d want 0", n_start); end
    total++; if (job_cnt !== 32'd1) begin bad++; $display("FAIL zero_job_cnt: got %0d want 1", job_cnt); end
  endtask

  task automatic test_timeout();
    int c;
    do_reset();
    clear_rec();
    rounds_i = 64'h0002_0000_0000_0000;
    req = 4'b1000;
    c = cyc;
    observe(22);
    total++; if (n_start != 1 || first_start_cyc != c + 2) begin bad++; $display("FAIL tmo_start: got n=%0d cyc %0d want n=1 cyc %0d", n_start, first_start_cyc, c + 2); end
    total++; if (n_err != 1 || err_or !== 4'b1000 || err_cyc != c + 19) begin bad++; $display("FAIL tmo_err: got n=%0d %b cyc %0d want n=1 1000 cyc %0d", n_err, err_or, err_cyc, c + 19); end
    total++; if (n_done != 0 || job_cnt !== 32'd0) begin bad++; $display("FAIL tmo_no_done: got done=%0d cnt=%0d want 0/0", n_done, job_cnt); end
    total++; if (rounds_left !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_idle: got left=%0d busy=%b want 0/0", rounds_left, busy); end
    clear_rec();
    rounds_i = '0;
    req = 4'b1001;
    observe(5);
    total++; if (gnt_first !== 4'b0001) begin bad++; $display("FAIL tmo_ptr_wrap: got first gnt %b want 0001", gnt_first); end
  endtask

  task automatic test_ignore_done();
    do_reset();
    rounds_i = 64'h0000_0000_0002_0000;
    eng_done_man = 1'b1;
    @(negedge clk);
    eng_done_man = 1'b0;
    total++; if (busy !== 1'b0 || rounds_left !== 16'd0 || eng_start !== 1'b0) begin bad++; $display("FAIL ign_idle: got busy=%b left=%0d start=%b want 0/0/0", busy, rounds_left, eng_start); end
    req = 4'b0010;
    @(negedge clk);
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ign_gnt: got %b want 0010", gnt); end
    req = '0;
    @(negedge clk);
    total++; if (eng_start !== 1'b1) begin bad++; $display("FAIL ign_start: got %b want 1", eng_start); end
    eng_done_man = 1'b1;
    @(negedge clk);
    eng_done_man = 1'b0;
    total++; if (rounds_left !== 16'd2 || busy !== 1'b1 || eng_start !== 1'b0) begin bad++; $display("FAIL ign_start_cycle: got left=%0d busy=%b start=%b want 2/1/0", rounds_left, busy, eng_start); end
    @(negedge clk);
    eng_done_man = 1'b1;
    @(negedge clk);
    eng_done_man = 1'b0;
    total++; if (rounds_left !== 16'd1 || eng_start !== 1'b1) begin bad++; $display("FAIL ign_real_done: got left=%0d start=%b want 1/1", rounds_left, eng_start); end
  endtask

  task automatic test_reset_midjob();
    int c;
    do_reset();
    rounds_i = 64'h0000_0000_0005_0000;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1 || eng_sel !== 2'd1) begin bad++; $display("FAIL mid_wait: got busy=%b sel=%0d want 1/1", busy, eng_sel); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0 || gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || eng_start !== 1'b0) begin bad++; $display("FAIL mid_outputs: got busy=%b gnt=%b done=%b err=%b start=%b want all 0", busy, gnt, done, err, eng_start); end
    total++; if (eng_sel !== 2'd0 || rounds_left !== 16'd0 || job_cnt !== 32'd0) begin bad++; $display("FAIL mid_regs: got sel=%0d left=%0d cnt=%0d want 0/0/0", eng_sel, rounds_left, job_cnt); end
    clear_rec();
    observe(3);
    total++; if (n_done != 0 || n_err != 0) begin bad++; $display("FAIL mid_silent: got done=%0d err=%0d want 0/0", n_done, n_err); end
    clear_rec();
    eng_delay = 1;
    rounds_i = 64'h0000_0001_0000_0000;
    req = 4'b0100;
    c = cyc;
    observe(7);
    total++; if (gnt_cyc != c + 1 || gnt_or !== 4'b0100) begin bad++; $display("FAIL mid_regrant: got cyc %0d %b want cyc %0d 0100", gnt_cyc, gnt_or, c + 1); end
    total++; if (n_done != 1 || done_or !== 4'b0100 || job_cnt !== 32'd1) begin bad++; $display("FAIL mid_job: got done=%0d %b cnt=%0d want 1 0100 1", n_done, done_or, job_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_rounds();
    test_timeout();
    test_ignore_done();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mix_engine_arbiter.md
Name: mix_engine_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8x32 mixing engine between NREQ requesters.
- A granted requester gets a job of N consecutive mixing rounds. The arbiter issues one eng_start per round, waits for eng_done each time, then signals completion to the owner.
- It has a per-round timeout watchdog and a completed-job counter.
- It sits between the requester blocks and the shared engine; the engine's 8x32 data path does not pass through this block.

Parameters:
- NREQ, 4, number of requesters (2..16).
- RW, 16, width of each requester's round-count field.
- TMO, 1024, watchdog limit in cycles per round (>=2).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  request; requester i holds req[i] high until it sees gnt[i].
- rounds_i  in  NREQ*RW  round count; requester i uses bits [i*RW +: RW].
- gnt  out  NREQ  one-hot, single-cycle grant.
- done  out  NREQ  one-hot, single-cycle job-complete to the owner.
- err  out  NREQ  one-hot, single-cycle timeout abort to the owner.
- eng_start  out  1  single-cycle start of one engine round.
- eng_sel  out  max(1,$clog2(NREQ))  current owner index.
- eng_done  in  1  engine round-complete pulse.
- busy  out  1  high whenever state != IDLE.
- rounds_left  out  RW  rounds remaining in the current job.
- job_cnt  out  32  count of completed jobs; wraps modulo 2^32.

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, owner=0, left=0, timer=0, job_cnt=0.
  - All outputs are 0.
  - Reset mid-job aborts silently: no done or err pulse.
- Outputs are Moore-decoded from the registered state:
  - gnt[owner]=1 only in GRANT.
  - eng_start=1 only in START.
  - done[owner]=1 only in FIN.
  - err[owner]=1 only in ERR.
  - eng_sel=owner and rounds_left=left at all times.
- Arbitration in IDLE:
  - Search req starting at index ptr, ascending, wrapping modulo NREQ.
  - The first set bit becomes owner, and left <= that requester's rounds_i field.
  - If any req is set, go to GRANT; otherwise stay in IDLE.
  - Latency: req sampled in IDLE at cycle t gives gnt at t+1.
- State transitions:
  - GRANT: go to START if left != 0, otherwise to FIN. A zero-round job completes with no engine activity.
  - START: timer <= 0, then go to WAIT.
  - WAIT, eng_done=1: if left==1, left <= 0 and go to FIN; otherwise left <= left-1 and go to START.
  - WAIT, eng_done=0 and timer==TMO-1: go to ERR.
  - WAIT, otherwise: timer <= timer+1.
  - eng_done takes priority over the timeout when both occur in the same cycle.
  - FIN: job_cnt <= job_cnt+1, ptr <= (owner+1) mod NREQ, then go to IDLE.
  - ERR: ptr <= (owner+1) mod NREQ, left <= 0, then go to IDLE. job_cnt is unchanged.
- eng_done outside WAIT, including in the START cycle, is ignored.
- Fastest round: START at t, eng_done at t+1, next START at t+2.
- Timeout timing: with START at cycle t and no eng_done, ERR occurs at cycle t+TMO+1.
- The req and rounds_i of non-owners are ignored while busy.
- An owner's req still high when the FSM returns to IDLE is a fresh request. It competes with the others, with ptr already moved past it.
- Back-to-back jobs: IDLE lasts at least one cycle between jobs.

Test Plan:
- NREQ=4, req[0]=1 with rounds=3, engine replies eng_done 2 cycles after each eng_start -> gnt=0001 one cycle after req, exactly 3 eng_start pulses, rounds_left goes 3,2,1,0, done=0001 once, job_cnt=1, busy=0 afterwards.
- req[0] and req[2] held continuously, rounds=1 each, eng_done 1 cycle after start -> grant order 0,2,0,2,0; job_cnt increments once per job.
- req[1]=1 with rounds=0 -> gnt=0010, then done=0010 on the next cycle, no eng_start, job_cnt=1.
- TMO=16, req[3]=1 with rounds=2, engine silent -> one eng_start at t, err=1000 at t+17, no done, job_cnt=0; next arbitration starts at ptr=0.
- eng_done pulses while IDLE and in the START cycle -> ignored; rounds_left is not decremented.
- rst=1 during WAIT of a rounds=5 job -> next cycle: IDLE, all outputs 0, job_cnt=0, no done/err pulse; a subsequent req[2] is granted normally.
